// File: rtl/spi_slave_word.sv
// SPI slave that oversamples SCK/CS_n/MOSI in the in_clk domain and exchanges
// whole WIDTH-bit words with internal logic through valid/ready handshakes.
module spi_slave_word #(
    parameter int WIDTH     = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_sck,
    input  logic             in_cs_n,
    input  logic             in_mosi,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic [WIDTH-1:0] in_tx_data,
    input  logic             in_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    input  logic             in_rx_ready,
    output logic             o_rx_overrun,
    output logic             o_busy
);

    localparam int            CW          = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT    = CW'(WIDTH - 1);
    localparam bit            SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sck_sync_q;
    logic [1:0]       cs_sync_q;
    logic [1:0]       mosi_sync_q;
    logic             sck_last_q;
    logic             mosi_last_q;
    logic             sample_stb_q;
    logic             shift_stb_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_empty_q, hold_empty_d;
    logic             word_edge_q, word_edge_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q, overrun_d;
    logic             miso_q, miso_d;

    logic             rise_s;
    logic             fall_s;
    logic             sample_edge_s;
    logic             shift_edge_s;
    logic             word_done_s;
    logic             load_s;
    logic [WIDTH-1:0] rx_word_s;

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            out_bit = v[WIDTH-1];
        end else begin
            out_bit = v[0];
        end
    endfunction

    function automatic logic [WIDTH-1:0] tx_advance(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            tx_advance = {v[WIDTH-2:0], 1'b0};
        end else begin
            tx_advance = {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    function automatic logic [WIDTH-1:0] rx_insert(input logic [WIDTH-1:0] v, input logic b);
        if (MSB_FIRST) begin
            rx_insert = {v[WIDTH-2:0], b};
        end else begin
            rx_insert = {b, v[WIDTH-1:1]};
        end
    endfunction

    always_comb begin
        rise_s        = sck_sync_q[1] & ~sck_last_q;
        fall_s        = ~sck_sync_q[1] & sck_last_q;
        sample_edge_s = SAMPLE_RISE ? rise_s : fall_s;
        shift_edge_s  = SAMPLE_RISE ? fall_s : rise_s;
    end

    // word_edge_q marks the first shift strobe of a word: for CPHA=0 it loads
    // the next word, for CPHA=1 it leaves the first bit in place.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        hold_d       = hold_q;
        hold_empty_d = hold_empty_q;
        word_edge_d  = word_edge_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        overrun_d    = 1'b0;
        word_done_s  = 1'b0;
        load_s       = 1'b0;
        rx_word_s    = rx_insert(rx_shift_q, mosi_last_q);

        case (state_q)
            ST_IDLE: begin
                if (!cs_sync_q[1]) begin
                    state_d     = ST_ACTIVE;
                    cnt_d       = '0;
                    rx_shift_d  = '0;
                    load_s      = 1'b1;
                    word_edge_d = CPHA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (sample_stb_q) begin
                    rx_shift_d = rx_word_s;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d       = '0;
                        word_done_s = 1'b1;
                        word_edge_d = 1'b1;
                        load_s      = CPHA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (shift_stb_q) begin
                    if (word_edge_q) begin
                        word_edge_d = 1'b0;
                        load_s      = ~CPHA;
                    end else begin
                        tx_shift_d = tx_advance(tx_shift_q);
                    end
                end else begin
                    cnt_d = cnt_q;
                end

                // A word completing in the same cycle as CS release still
                // delivers its RX data, but nothing new is pulled for TX.
                if (cs_sync_q[1]) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    rx_shift_d  = '0;
                    tx_shift_d  = '0;
                    word_edge_d = 1'b0;
                    load_s      = 1'b0;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            tx_shift_d   = hold_empty_q ? '0 : hold_q;
            hold_empty_d = 1'b1;
        end else begin
            hold_empty_d = hold_empty_d;
        end

        if (in_tx_valid && hold_empty_q) begin
            hold_d       = in_tx_data;
            hold_empty_d = 1'b0;
        end else begin
            hold_d = hold_q;
        end

        if (rx_valid_q && in_rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        if (word_done_s) begin
            if (!rx_valid_q || in_rx_ready) begin
                rx_data_d  = rx_word_s;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            rx_data_d = rx_data_q;
        end

        if (state_d == ST_ACTIVE) begin
            miso_d = out_bit(tx_shift_d);
        end else begin
            miso_d = 1'b0;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            sck_sync_q   <= {2{CPOL}};
            cs_sync_q    <= 2'b11;
            mosi_sync_q  <= 2'b00;
            sck_last_q   <= CPOL;
            mosi_last_q  <= 1'b0;
            sample_stb_q <= 1'b0;
            shift_stb_q  <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            hold_q       <= '0;
            hold_empty_q <= 1'b1;
            word_edge_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            miso_q       <= 1'b0;
        end else begin
            sck_sync_q   <= {sck_sync_q[0], in_sck};
            cs_sync_q    <= {cs_sync_q[0], in_cs_n};
            mosi_sync_q  <= {mosi_sync_q[0], in_mosi};
            sck_last_q   <= sck_sync_q[1];
            mosi_last_q  <= mosi_sync_q[1];
            sample_stb_q <= sample_edge_s;
            shift_stb_q  <= shift_edge_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            hold_empty_q <= hold_empty_d;
            word_edge_q  <= word_edge_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            overrun_q    <= overrun_d;
            miso_q       <= miso_d;
        end
    end

    assign o_miso       = miso_q;
    assign o_miso_oe    = (state_q == ST_ACTIVE);
    assign o_busy       = (state_q == ST_ACTIVE);
    assign o_tx_ready   = hold_empty_q;
    assign o_rx_data    = rx_data_q;
    assign o_rx_valid   = rx_valid_q;
    assign o_rx_overrun = overrun_q;

endmodule

// File: tb/tb_spi_slave_word.sv
// Directed bench for spi_slave_word: five 8-bit instances (modes 0-3 and an
// LSB-first mode 0) plus one 16-bit mode-0 instance on a shared SPI bus.
module tb_spi_slave_word;

    logic        in_clk;
    logic        in_rst;
    logic        sck;
    logic        mosi;
    logic [5:0]  cs_n;
    logic [5:0]  tx_valid;
    logic [5:0]  rx_ready;
    wire  [5:0]  miso;
    wire  [5:0]  oe;
    wire  [5:0]  tx_ready;
    wire  [5:0]  rx_valid;
    wire  [5:0]  ovr;
    wire  [5:0]  busy;
    logic [7:0]  tx8 [5];
    wire  [7:0]  rx8 [5];
    logic [15:0] tx16;
    wire  [15:0] rx16;
    wire         miso_bus = |miso;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    int   vrise0  = 0;
    int   ovr0    = 0;
    logic v0_prev = 1'b0;

    for (genvar g = 0; g < 5; g++) begin : g_w8
        spi_slave_word #(
            .WIDTH(8), .CPOL(g == 2 || g == 3), .CPHA(g == 1 || g == 3), .MSB_FIRST(g != 4)
        ) u_dut (
            .in_clk(in_clk), .in_rst(in_rst), .in_sck(sck), .in_cs_n(cs_n[g]),
            .in_mosi(mosi), .o_miso(miso[g]), .o_miso_oe(oe[g]),
            .in_tx_data(tx8[g]), .in_tx_valid(tx_valid[g]), .o_tx_ready(tx_ready[g]),
            .o_rx_data(rx8[g]), .o_rx_valid(rx_valid[g]), .in_rx_ready(rx_ready[g]),
            .o_rx_overrun(ovr[g]), .o_busy(busy[g])
        );
    end

    spi_slave_word #(
        .WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)
    ) u_dut16 (
        .in_clk(in_clk), .in_rst(in_rst), .in_sck(sck), .in_cs_n(cs_n[5]),
        .in_mosi(mosi), .o_miso(miso[5]), .o_miso_oe(oe[5]),
        .in_tx_data(tx16), .in_tx_valid(tx_valid[5]), .o_tx_ready(tx_ready[5]),
        .o_rx_data(rx16), .o_rx_valid(rx_valid[5]), .in_rx_ready(rx_ready[5]),
        .o_rx_overrun(ovr[5]), .o_busy(busy[5])
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Count o_rx_valid rising edges and o_rx_overrun high cycles of instance 0.
    always @(negedge in_clk) begin
        v0_prev <= rx_valid[0];
        if (rx_valid[0] && !v0_prev) vrise0 <= vrise0 + 1;
        if (ovr[0]) ovr0 <= ovr0 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cs_low(input int idx, input bit cpol);
        sck = cpol;
        tick(4);
        cs_n[idx] = 1'b0;
        tick(8);
    endtask

    task automatic cs_high(input int idx);
        cs_n[idx] = 1'b1;
        tick(8);
    endtask

    task automatic put8(input int idx, input logic [7:0] d);
        tx8[idx] = d;
        tx_valid[idx] = 1'b1;
        tick(1);
        tx_valid[idx] = 1'b0;
    endtask

    task automatic put16(input logic [15:0] d);
        tx16 = d;
        tx_valid[5] = 1'b1;
        tick(1);
        tx_valid[5] = 1'b0;
    endtask

    task automatic accept(input int idx);
        rx_ready[idx] = 1'b1;
        tick(1);
        rx_ready[idx] = 1'b0;
    endtask

    // Master side of one word (or nbits of it); half SCK period = 8 clocks.
    task automatic xfer(input bit cpol, input bit cpha, input bit msb, input int w,
                        input int nbits, input logic [15:0] dout, output logic [15:0] din);
        din = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = msb ? (w - 1 - i) : i;
            if (!cpha) begin
                mosi = dout[b];
                tick(8);
                din[b] = miso_bus;
                sck = ~cpol;
                tick(8);
                sck = cpol;
            end else begin
                sck = ~cpol;
                mosi = dout[b];
                tick(8);
                din[b] = miso_bus;
                sck = cpol;
                tick(8);
            end
        end
        if (!cpha) tick(8);
    endtask

    initial begin
        logic [15:0] r;
        int vbase;
        int obase;
        in_rst   = 1'b1;
        sck      = 1'b0;
        mosi     = 1'b0;
        cs_n     = 6'h3f;
        tx_valid = 6'h00;
        rx_ready = 6'h00;
        tx16     = 16'h0000;
        for (int i = 0; i < 5; i++) tx8[i] = 8'h00;
        tick(3);
        in_rst = 1'b0;
        tick(2);

        check("rst_busy", {26'h0, busy}, 32'h0);
        check("rst_oe", {26'h0, oe}, 32'h0);
        check("rst_miso", {26'h0, miso}, 32'h0);
        check("rst_tx_ready", {26'h0, tx_ready}, 32'h3f);
        check("rst_rx_valid", {26'h0, rx_valid}, 32'h0);
        check("rst_overrun", {26'h0, ovr}, 32'h0);
        check("rst_rx_data", {24'h0, rx8[0]}, 32'h0);

        // Mode 0, preloaded 0x3C, master sends 0xA5.
        put8(0, 8'h3C);
        check("m0_hold_full", {31'h0, tx_ready[0]}, 32'h0);
        cs_low(0, 1'b0);
        check("m0_busy", {31'h0, busy[0]}, 32'h1);
        check("m0_oe", {31'h0, oe[0]}, 32'h1);
        check("m0_hold_moved", {31'h0, tx_ready[0]}, 32'h1);
        xfer(1'b0, 1'b0, 1'b1, 8, 8, 16'h00A5, r);
        check("m0_miso", {24'h0, r[7:0]}, 32'h3C);
        check("m0_rx_data", {24'h0, rx8[0]}, 32'hA5);
        check("m0_rx_valid", {31'h0, rx_valid[0]}, 32'h1);
        accept(0);
        check("m0_rx_taken", {31'h0, rx_valid[0]}, 32'h0);
        cs_high(0);
        check("m0_idle_busy", {31'h0, busy[0]}, 32'h0);
        check("m0_idle_oe", {31'h0, oe[0]}, 32'h0);
        check("m0_single_valid", vrise0, 32'd1);

        // Modes 1..3: master sends 0x5A, slave returns 0xC3.
        for (int m = 1; m <= 3; m++) begin
            bit cpol;
            bit cpha;
            cpol = (m >= 2);
            cpha = (m == 1 || m == 3);
            put8(m, 8'hC3);
            cs_low(m, cpol);
            xfer(cpol, cpha, 1'b1, 8, 8, 16'h005A, r);
            cs_high(m);
            check($sformatf("mode%0d_miso", m), {24'h0, r[7:0]}, 32'hC3);
            check($sformatf("mode%0d_rx", m), {24'h0, rx8[m]}, 32'h5A);
            check($sformatf("mode%0d_valid", m), {31'h0, rx_valid[m]}, 32'h1);
            accept(m);
        end

        // LSB-first instance: symmetric and asymmetric words.
        put8(4, 8'hC3);
        cs_low(4, 1'b0);
        xfer(1'b0, 1'b0, 1'b0, 8, 8, 16'h005A, r);
        cs_high(4);
        check("lsb_miso_c3", {24'h0, r[7:0]}, 32'hC3);
        check("lsb_rx_5a", {24'h0, rx8[4]}, 32'h5A);
        accept(4);
        put8(4, 8'h0B);
        cs_low(4, 1'b0);
        xfer(1'b0, 1'b0, 1'b1, 8, 8, 16'h0078, r);
        cs_high(4);
        check("lsb_wire_order", {24'h0, r[7:0]}, 32'hD0);
        check("lsb_rx_1e", {24'h0, rx8[4]}, 32'h1E);
        accept(4);

        // 16-bit burst of three words under one CS.
        put16(16'h1234);
        cs_low(5, 1'b0);
        check("burst_ready0", {31'h0, tx_ready[5]}, 32'h1);
        put16(16'h5678);
        xfer(1'b0, 1'b0, 1'b1, 16, 16, 16'hA1B2, r);
        check("burst_miso0", {16'h0, r}, 32'h1234);
        check("burst_rx0", {16'h0, rx16}, 32'hA1B2);
        check("burst_ready1", {31'h0, tx_ready[5]}, 32'h1);
        accept(5);
        put16(16'h9ABC);
        xfer(1'b0, 1'b0, 1'b1, 16, 16, 16'hC3D4, r);
        check("burst_miso1", {16'h0, r}, 32'h5678);
        check("burst_rx1", {16'h0, rx16}, 32'hC3D4);
        accept(5);
        xfer(1'b0, 1'b0, 1'b1, 16, 16, 16'hE5F6, r);
        check("burst_miso2", {16'h0, r}, 32'h9ABC);
        check("burst_rx2", {16'h0, rx16}, 32'hE5F6);
        check("burst_valid2", {31'h0, rx_valid[5]}, 32'h1);
        check("burst_overrun", {31'h0, ovr[5]}, 32'h0);
        cs_high(5);
        accept(5);

        // Overrun: consumer stalls across two words.
        obase = ovr0;
        cs_low(0, 1'b0);
        xfer(1'b0, 1'b0, 1'b1, 8, 8, 16'h0011, r);
        check("ovr_underrun_miso", {24'h0, r[7:0]}, 32'h00);
        check("ovr_rx_first", {24'h0, rx8[0]}, 32'h11);
        check("ovr_valid_first", {31'h0, rx_valid[0]}, 32'h1);
        xfer(1'b0, 1'b0, 1'b1, 8, 8, 16'h0022, r);
        cs_high(0);
        check("ovr_rx_held", {24'h0, rx8[0]}, 32'h11);
        check("ovr_valid_held", {31'h0, rx_valid[0]}, 32'h1);
        check("ovr_pulse_count", ovr0 - obase, 32'd1);
        accept(0);

        // Partial word discarded, then a full 0x7E with no TX data.
        vbase = vrise0;
        cs_low(0, 1'b0);
        xfer(1'b0, 1'b0, 1'b1, 8, 3, 16'h00FF, r);
        cs_high(0);
        check("partial_no_valid", {31'h0, rx_valid[0]}, 32'h0);
        check("partial_no_rise", vrise0 - vbase, 32'd0);
        check("partial_no_ovr", ovr0 - obase, 32'd1);
        cs_low(0, 1'b0);
        xfer(1'b0, 1'b0, 1'b1, 8, 8, 16'h007E, r);
        cs_high(0);
        check("after_partial_rx", {24'h0, rx8[0]}, 32'h7E);
        check("after_partial_valid", {31'h0, rx_valid[0]}, 32'h1);
        check("after_partial_miso", {24'h0, r[7:0]}, 32'h00);

        // Reset mid-word with a word pending and the holding register full.
        cs_low(0, 1'b0);
        put8(0, 8'h99);
        check("rst_pre_hold_full", {31'h0, tx_ready[0]}, 32'h0);
        xfer(1'b0, 1'b0, 1'b1, 8, 4, 16'h00FF, r);
        in_rst = 1'b1;
        tick(1);
        check("midrst_busy", {31'h0, busy[0]}, 32'h0);
        check("midrst_oe", {31'h0, oe[0]}, 32'h0);
        check("midrst_miso", {31'h0, miso[0]}, 32'h0);
        check("midrst_tx_ready", {31'h0, tx_ready[0]}, 32'h1);
        check("midrst_rx_valid", {31'h0, rx_valid[0]}, 32'h0);
        check("midrst_rx_data", {24'h0, rx8[0]}, 32'h0);
        cs_n[0] = 1'b1;
        tick(2);
        in_rst = 1'b0;
        tick(4);
        cs_low(0, 1'b0);
        xfer(1'b0, 1'b0, 1'b1, 8, 8, 16'h0081, r);
        cs_high(0);
        check("postrst_rx", {24'h0, rx8[0]}, 32'h81);
        check("postrst_valid", {31'h0, rx_valid[0]}, 32'h1);
        check("postrst_miso", {24'h0, r[7:0]}, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
